// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: data-memory slave for the core's XM/MW stages.
// Accepts a load/store request over a valid/yumi handshake, performs the
// access against a word-organised array after a fixed latency, and holds
// the response until the core acknowledges it.
//
// Ports:
//   clk         clock
//   reset       asynchronous, active-high reset
//   to_mem_i    request  {write_data[31:0], valid, wen, byte_not_word, yumi}
//   addr_i      byte address, sampled with the request
//   from_mem_o  response {read_data[31:0], valid, yumi}
//   busy_o      high whenever the controller is not idle
//   ld_count_o  accepted loads, saturating
//   st_count_o  accepted stores, saturating
//
// States:
//   IDLE | waiting for a request; yumi mirrors request valid
//   BUSY | latency countdown; access happens when the counter hits 0
//   RESP | response valid, held until to_mem_i yumi
module data_mem_ctrl #(
    parameter int addr_width_p = 10,
    parameter int latency_p    = 2,
    parameter int cnt_width_p  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [35:0]            to_mem_i,
    input  logic [31:0]            addr_i,
    output logic [33:0]            from_mem_o,
    output logic                   busy_o,
    output logic [cnt_width_p-1:0] ld_count_o,
    output logic [cnt_width_p-1:0] st_count_o
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    state_e state_q, state_d;

    logic [31:0] req_wdata;
    logic        req_valid, req_wen, req_bnw, resp_ack;
    assign {req_wdata, req_valid, req_wen, req_bnw, resp_ack} = to_mem_i;

    // Bits above the array span alias; they are deliberately dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr_i[31:addr_width_p+2];

    logic [2:0]              cnt_q;
    logic [addr_width_p+1:0] addr_q;
    logic [31:0]             wdata_q;
    logic                    wen_q, bnw_q;
    logic [31:0]             rdata_q;
    logic [cnt_width_p-1:0]  ld_cnt_q, st_cnt_q;

    logic [31:0] mem_q [2**addr_width_p];

    logic                    accept, access;
    logic [addr_width_p-1:0] word_idx;
    logic [1:0]              lane;
    logic [31:0]             rd_word, merged_word;
    logic [7:0]              rd_byte;

    assign word_idx = addr_q[addr_width_p+1:2];
    assign lane     = addr_q[1:0];
    assign rd_word  = mem_q[word_idx];

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (req_valid)     state_d = BUSY;
            BUSY: if (cnt_q == 3'd0) state_d = RESP;
            RESP: if (resp_ack)      state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        accept = 1'b0;
        access = 1'b0;
        busy_o = 1'b1;
        case (state_q)
            IDLE: begin
                accept = req_valid;
                busy_o = 1'b0;
            end
            BUSY:    access = (cnt_q == 3'd0);
            default: ;
        endcase
    end

    assign from_mem_o = {rdata_q, (state_q == RESP), accept};
    assign ld_count_o = ld_cnt_q;
    assign st_count_o = st_cnt_q;

    always_comb begin
        merged_word = rd_word;
        rd_byte     = rd_word[7:0];
        case (lane)
            2'd0: begin merged_word[7:0]   = wdata_q[7:0]; rd_byte = rd_word[7:0];   end
            2'd1: begin merged_word[15:8]  = wdata_q[7:0]; rd_byte = rd_word[15:8];  end
            2'd2: begin merged_word[23:16] = wdata_q[7:0]; rd_byte = rd_word[23:16]; end
            default: begin merged_word[31:24] = wdata_q[7:0]; rd_byte = rd_word[31:24]; end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wen_q    <= 1'b0;
            bnw_q    <= 1'b0;
            rdata_q  <= '0;
            ld_cnt_q <= '0;
            st_cnt_q <= '0;
        end else begin
            if (accept) begin
                addr_q  <= addr_i[addr_width_p+1:0];
                wdata_q <= req_wdata;
                wen_q   <= req_wen;
                bnw_q   <= req_bnw;
                cnt_q   <= 3'(latency_p - 1);
                if (req_wen) begin
                    if (st_cnt_q != '1) st_cnt_q <= st_cnt_q + 1'b1;
                end else begin
                    if (ld_cnt_q != '1) ld_cnt_q <= ld_cnt_q + 1'b1;
                end
            end else if (state_q == BUSY && cnt_q != 3'd0) begin
                cnt_q <= cnt_q - 3'd1;
            end
            if (access) begin
                if (wen_q)      rdata_q <= '0;
                else if (bnw_q) rdata_q <= {24'd0, rd_byte};
                else            rdata_q <= rd_word;
            end
        end
    end

    // Array has no reset; a reset during BUSY leaves state_q at IDLE so the
    // pending store never reaches this write.
    always_ff @(posedge clk) begin
        if (access && wen_q) begin
            mem_q[word_idx] <= bnw_q ? merged_word : wdata_q;
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] wdata;
    logic        vld, wen, bnw, ack;
    logic [31:0] addr;
    logic [35:0] to_mem;
    logic [33:0] from_mem;
    logic        busy;
    logic [1:0]  ld_cnt, st_cnt;

    logic [31:0] r_data;
    logic        r_valid, r_yumi;
    logic [31:0] rd;

    int errors = 0;
    int checks = 0;

    assign to_mem = {wdata, vld, wen, bnw, ack};
    assign {r_data, r_valid, r_yumi} = from_mem;

    always #5 clk = ~clk;

    data_mem_ctrl #(.addr_width_p(10), .latency_p(2), .cnt_width_p(2)) dut (
        .clk(clk), .reset(reset), .to_mem_i(to_mem), .addr_i(addr),
        .from_mem_o(from_mem), .busy_o(busy),
        .ld_count_o(ld_cnt), .st_count_o(st_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full transaction: request at a negedge, exact latency checks, then
    // immediate acknowledge. Returns read_data seen in RESP.
    task automatic xfer(input logic [31:0] a, input logic [31:0] d,
                        input logic w, input logic b, output logic [31:0] res);
        @(negedge clk);
        addr = a; wdata = d; wen = w; bnw = b; vld = 1'b1;
        #1 chk("req_yumi", {31'd0, r_yumi}, 32'd1);
        @(negedge clk);
        vld = 1'b0; addr = 32'hFFFF_FFFF; wdata = 32'hA5A5_A5A5;
        #1 chk("busy_t1", {31'd0, busy}, 32'd1);
        chk("valid_t1", {31'd0, r_valid}, 32'd0);
        @(negedge clk);
        #1 chk("valid_t2", {31'd0, r_valid}, 32'd0);
        @(negedge clk);
        #1 chk("valid_t3", {31'd0, r_valid}, 32'd1);
        res = r_data;
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        #1 chk("valid_after_ack", {31'd0, r_valid}, 32'd0);
        chk("idle_after_ack", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; vld = 1'b0; wen = 1'b0; bnw = 1'b0; ack = 1'b0;
        wdata = '0; addr = '0;
        #12;
        chk("rst_valid", {31'd0, r_valid}, 32'd0);
        chk("rst_yumi", {31'd0, r_yumi}, 32'd0);
        chk("rst_rdata", r_data, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_cnts", {28'd0, ld_cnt, st_cnt}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Word store then load
        xfer(32'h10, 32'hDEADBEEF, 1'b1, 1'b0, rd);
        chk("store_rdata", rd, 32'd0);
        xfer(32'h10, 32'h0, 1'b0, 1'b0, rd);
        chk("word_load", rd, 32'hDEADBEEF);
        chk("st_count1", {30'd0, st_cnt}, 32'd1);
        chk("ld_count1", {30'd0, ld_cnt}, 32'd1);

        // Byte lanes
        xfer(32'h20, 32'h11223344, 1'b1, 1'b0, rd);
        xfer(32'h22, 32'hFFFF_FFAA, 1'b1, 1'b1, rd);
        xfer(32'h20, 32'h0, 1'b0, 1'b0, rd);
        chk("byte_merge", rd, 32'h11AA3344);
        xfer(32'h23, 32'h0, 1'b0, 1'b1, rd);
        chk("byte_load3", rd, 32'h00000011);
        xfer(32'h20, 32'h0, 1'b0, 1'b1, rd);
        chk("byte_load0", rd, 32'h00000044);

        // Aliasing: 0x1004 and 0x0004 share word 1
        xfer(32'h1004, 32'h5, 1'b1, 1'b0, rd);
        xfer(32'h0004, 32'h0, 1'b0, 1'b0, rd);
        chk("alias", rd, 32'h5);

        // Delayed acknowledge with a new request pending during RESP
        @(negedge clk);
        addr = 32'h10; wen = 1'b0; bnw = 1'b0; vld = 1'b1;
        @(negedge clk); vld = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 chk("dly_valid0", {31'd0, r_valid}, 32'd1);
        addr = 32'h20; vld = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1 chk("dly_valid", {31'd0, r_valid}, 32'd1);
            chk("dly_rdata", r_data, 32'hDEADBEEF);
            chk("dly_no_yumi", {31'd0, r_yumi}, 32'd0);
            @(negedge clk);
        end
        ack = 1'b1;
        #1 chk("ack_cycle_no_yumi", {31'd0, r_yumi}, 32'd0);
        @(negedge clk);
        ack = 1'b0;
        #1 chk("after_ack_yumi", {31'd0, r_yumi}, 32'd1);
        chk("after_ack_valid", {31'd0, r_valid}, 32'd0);
        @(negedge clk); vld = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 chk("pend_load_valid", {31'd0, r_valid}, 32'd1);
        chk("pend_load_rdata", r_data, 32'h11AA3344);
        ack = 1'b1;
        @(negedge clk); ack = 1'b0;

        // Reset mid-BUSY drops the pending store
        xfer(32'h30, 32'h12345678, 1'b1, 1'b0, rd);
        @(negedge clk);
        addr = 32'h30; wdata = 32'h77; wen = 1'b1; bnw = 1'b0; vld = 1'b1;
        @(negedge clk);
        vld = 1'b0; reset = 1'b1;
        #1 chk("midrst_valid", {31'd0, r_valid}, 32'd0);
        chk("midrst_yumi", {31'd0, r_yumi}, 32'd0);
        chk("midrst_rdata", r_data, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_cnts", {28'd0, ld_cnt, st_cnt}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        xfer(32'h30, 32'h0, 1'b0, 1'b0, rd);
        chk("store_dropped", rd, 32'h12345678);

        // Counter saturation at 2 bits
        xfer(32'h10, 32'h0, 1'b0, 1'b0, rd);
        xfer(32'h10, 32'h0, 1'b0, 1'b0, rd);
        chk("ld_count3", {30'd0, ld_cnt}, 32'd3);
        xfer(32'h10, 32'h0, 1'b0, 1'b0, rd);
        xfer(32'h10, 32'h0, 1'b0, 1'b0, rd);
        chk("ld_count_sat", {30'd0, ld_cnt}, 32'd3);
        chk("st_count_post", {30'd0, st_cnt}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
